// File: rtl/alu_controlador.sv
// -----------------------------------------------------------------------------
// alu_controlador
// Command front-end and result buffer for the 8-bit ALU.
//  - Accepts {opcode, Dato0, Dato1} commands over a valid/ready handshake and
//    drives the ALU inputs from registers (alu_op, alu_dato0, alu_dato1).
//  - One cycle after acceptance it captures the ALU result and flags, or an
//    error entry for division/modulo by zero, into a result FIFO.
//  - The FIFO head is offered to a consumer over a second valid/ready handshake.
// Ports:
//  clk, rst_n                      clock, asynchronous active-low reset
//  cmd_valido/cmd_listo            command handshake
//  cmd_op, cmd_a, cmd_b            command opcode and operands
//  alu_op, alu_dato0, alu_dato1    registered ALU inputs
//  alu_resultado, alu_banderaA/B   ALU result, carry/borrow flag, zero flag
//  res_valido/res_listo            result handshake
//  res_dato, res_acarreo,
//  res_cero, res_error             FIFO head entry
//  err_cuenta                      saturating count of div/mod-by-zero commands
// PROF_FIFO must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module alu_controlador #(
   parameter int PROF_FIFO = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valido,
   output logic        cmd_listo,
   input  logic [2:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic [2:0]  alu_op,
   output logic [7:0]  alu_dato0,
   output logic [7:0]  alu_dato1,
   input  logic [15:0] alu_resultado,
   input  logic        alu_banderaA,
   input  logic        alu_banderaB,
   output logic        res_valido,
   input  logic        res_listo,
   output logic [15:0] res_dato,
   output logic        res_acarreo,
   output logic        res_cero,
   output logic        res_error,
   output logic [7:0]  err_cuenta
);

   localparam int          PW       = (PROF_FIFO > 1) ? $clog2(PROF_FIFO) : 1;
   localparam logic [PW:0] OCC_MAX  = (PW+1)'(PROF_FIFO);
   localparam logic [PW:0] OCC_UNO  = 1;
   localparam logic [PW-1:0] PTR_UNO = 1;

   localparam logic [2:0] OP_SUM = 3'b000;
   localparam logic [2:0] OP_RES = 3'b001;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;

   typedef enum logic {INACTIVO, EJECUTAR} estado_t;

   estado_t       r_estado;
   logic          r_es_div0;
   logic [2:0]    r_op;
   logic [7:0]    r_dato0;
   logic [7:0]    r_dato1;
   logic [7:0]    r_err_cnt;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_occ;
   // Entry layout: {resultado[15:0], acarreo, cero, error}
   logic [18:0]   r_mem [PROF_FIFO];

   logic          w_acepta;
   logic          w_push;
   logic          w_pop;
   logic          w_acarreo;
   logic [18:0]   w_entrada;
   logic [18:0]   w_cabeza;

   // rst_n gates ready so nothing is offered while the block is held in reset.
   assign cmd_listo = rst_n & (r_estado == INACTIVO) & (r_occ < OCC_MAX);
   assign w_acepta  = cmd_valido & cmd_listo;
   // Capture happens in the single EJECUTAR cycle; acceptance already
   // guaranteed a free slot, so the push never sees a full FIFO.
   assign w_push    = (r_estado == EJECUTAR);
   assign w_pop     = res_valido & res_listo;

   // Only add/subtract produce a meaningful carry; other opcodes store 0.
   assign w_acarreo = alu_banderaA & ((r_op == OP_SUM) | (r_op == OP_RES));
   assign w_entrada = r_es_div0 ? {16'h0000, 1'b0, 1'b0, 1'b1}
                                : {alu_resultado, w_acarreo, alu_banderaB, 1'b0};

   assign res_valido = (r_occ != '0);
   assign w_cabeza   = r_mem[r_rd_ptr];
   assign {res_dato, res_acarreo, res_cero, res_error} = res_valido ? w_cabeza : 19'd0;

   assign alu_op     = r_op;
   assign alu_dato0  = r_dato0;
   assign alu_dato1  = r_dato1;
   assign err_cuenta = r_err_cnt;

   // Control: FSM, ALU operand registers, error counter, FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado  <= INACTIVO;
         r_es_div0 <= 1'b0;
         r_op      <= 3'b000;
         r_dato0   <= 8'h00;
         r_dato1   <= 8'h00;
         r_err_cnt <= 8'h00;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_occ     <= '0;
      end else begin
         case (r_estado)
            INACTIVO: begin
               if (w_acepta) begin
                  r_op      <= cmd_op;
                  r_dato0   <= cmd_a;
                  r_dato1   <= cmd_b;
                  r_es_div0 <= ((cmd_op == OP_DIV) | (cmd_op == OP_MOD)) & (cmd_b == 8'h00);
                  r_estado  <= EJECUTAR;
               end
            end
            EJECUTAR: begin
               if (r_es_div0 && (r_err_cnt != 8'hFF))
                  r_err_cnt <= r_err_cnt + 8'd1;
               r_estado <= INACTIVO;
            end
            default: r_estado <= INACTIVO;
         endcase

         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_UNO;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_UNO;

         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_UNO;
            2'b01:   r_occ <= r_occ - OCC_UNO;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Result storage: data only, no reset needed (occupancy masks stale slots)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_entrada;
   end

endmodule

// File: tb/tb_alu_controlador.sv
module tb_alu_controlador;

   localparam int PROF = 4;

   logic        clk;
   logic        rst_n;
   logic        cmd_valido;
   logic        cmd_listo;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  alu_op;
   logic [7:0]  alu_dato0;
   logic [7:0]  alu_dato1;
   logic [15:0] alu_resultado;
   logic        alu_banderaA;
   logic        alu_banderaB;
   logic        res_valido;
   logic        res_listo;
   logic [15:0] res_dato;
   logic        res_acarreo;
   logic        res_cero;
   logic        res_error;
   logic [7:0]  err_cuenta;

   int n_chk = 0;
   int n_err = 0;
   logic aleat = 1'b0;
   logic r_ruido = 1'b0;

   alu_controlador #(.PROF_FIFO(PROF)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valido(cmd_valido), .cmd_listo(cmd_listo),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_op(alu_op), .alu_dato0(alu_dato0), .alu_dato1(alu_dato1),
      .alu_resultado(alu_resultado), .alu_banderaA(alu_banderaA), .alu_banderaB(alu_banderaB),
      .res_valido(res_valido), .res_listo(res_listo),
      .res_dato(res_dato), .res_acarreo(res_acarreo), .res_cero(res_cero),
      .res_error(res_error), .err_cuenta(err_cuenta)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU behaviour: returns {carry/borrow, result}
   function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0]  t;
      logic [16:0] r;
      case (op)
         3'd0: begin t = {1'b0, a} + {1'b0, b}; r = {t[8], 7'h00, t}; end
         3'd1: begin t = {1'b0, a} - {1'b0, b}; r = {t[8], 8'h00, t[7:0]}; end
         3'd2: r = {1'b0, {8'h00, a} * {8'h00, b}};
         3'd3: r = (b == 8'h00) ? 17'h0FFFF : {9'h000, a / b};
         3'd4: r = (b == 8'h00) ? 17'h0FFFF : {9'h000, a % b};
         3'd5: r = {9'h000, a & b};
         3'd6: r = {9'h000, a | b};
         default: r = {9'h000, a ^ b};
      endcase
      return r;
   endfunction

   // Expected FIFO entry {resultado, acarreo, cero, error} for a command
   function automatic logic [18:0] esperado(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [16:0] t;
      t = alu_fn(op, a, b);
      if (((op == 3'd3) || (op == 3'd4)) && (b == 8'h00))
         return {16'h0000, 3'b001};
      return {t[15:0], (op <= 3'd1) ? t[16] : 1'b0, (t[15:0] == 16'h0000), 1'b0};
   endfunction

   // ALU environment; carry on non add/sub opcodes is random noise
   logic [16:0] w_alu;
   always_comb w_alu = alu_fn(alu_op, alu_dato0, alu_dato1);
   assign alu_resultado = w_alu[15:0];
   assign alu_banderaA  = (alu_op <= 3'd1) ? w_alu[16] : r_ruido;
   assign alu_banderaB  = (w_alu[15:0] == 16'h0000);
   always @(posedge clk) r_ruido <= 1'($urandom);

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_chk++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, obs, esp, $time);
      end
   endtask

   // Reference model: queue of expected entries plus the one command in flight
   logic [18:0] q[$];
   logic        m_ejec = 1'b0;
   logic        m_div0 = 1'b0;
   logic [18:0] m_ent  = '0;
   logic [18:0] m_cmd  = '0;
   logic [7:0]  m_err  = '0;
   logic        m_acc;
   logic        m_pop;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_ejec = 1'b0;
         m_div0 = 1'b0;
         m_cmd  = '0;
         m_err  = '0;
         comprobar("rst_cmd_listo", 32'(cmd_listo), 32'd0);
         comprobar("rst_res_valido", 32'(res_valido), 32'd0);
         comprobar("rst_res", 32'({res_dato, res_acarreo, res_cero, res_error}), 32'd0);
      end else begin
         comprobar("cmd_listo", 32'(cmd_listo), 32'(!m_ejec && (q.size() < PROF)));
         comprobar("res_valido", 32'(res_valido), 32'(q.size() != 0));
         comprobar("err_cuenta", 32'(err_cuenta), 32'(m_err));
         comprobar("alu_regs", 32'({alu_op, alu_dato0, alu_dato1}), 32'(m_cmd));
         if (q.size() != 0)
            comprobar("cabeza", 32'({res_dato, res_acarreo, res_cero, res_error}), 32'(q[0]));
         m_pop = (q.size() != 0) && res_listo;
         m_acc = cmd_valido && !m_ejec && (q.size() < PROF);
         if (m_pop) void'(q.pop_front());
         if (m_ejec) begin
            q.push_back(m_ent);
            if (m_div0 && (m_err != 8'hFF)) m_err = m_err + 8'd1;
         end
         m_ejec = m_acc;
         if (m_acc) begin
            m_cmd  = {cmd_op, cmd_a, cmd_b};
            m_ent  = esperado(cmd_op, cmd_a, cmd_b);
            m_div0 = ((cmd_op == 3'd3) || (cmd_op == 3'd4)) && (cmd_b == 8'h00);
         end
      end
   end

   task automatic ciclos(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a command and hold it until accepted (bounded)
   task automatic enviar(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valido = 1'b1;
      @(negedge clk);
      while (!cmd_listo && n < 50) begin
         @(posedge clk); #1;
         if (aleat) res_listo = 1'($urandom);
         @(negedge clk);
         n++;
      end
      comprobar("cmd_aceptado", 32'(cmd_listo), 32'd1);
      @(posedge clk); #1;
      cmd_valido = 1'b0;
      cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      if (aleat) res_listo = 1'($urandom);
   endtask

   // Pop exactly one entry at the next edge
   task automatic tomar();
      res_listo = 1'b1;
      @(posedge clk); #1;
      res_listo = 1'b0;
   endtask

   task automatic drenar();
      int n = 0;
      res_listo = 1'b1;
      @(negedge clk);
      while (res_valido && n < 20) begin
         @(negedge clk);
         n++;
      end
      comprobar("drenado", 32'(res_valido), 32'd0);
      @(posedge clk); #1;
      res_listo = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      rst_n = 1'b0; cmd_valido = 1'b0; res_listo = 1'b0;
      cmd_op = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0;

      // Reset state
      ciclos(3);
      comprobar("rst_listo", 32'(cmd_listo), 32'd0);
      comprobar("rst_alu", 32'({alu_op, alu_dato0, alu_dato1}), 32'd0);
      comprobar("rst_err", 32'(err_cuenta), 32'd0);
      comprobar("rst_valido", 32'(res_valido), 32'd0);
      rst_n = 1'b1;
      ciclos(1);

      // SUM with carry
      enviar(3'd0, 8'hFF, 8'h01);
      ciclos(1);
      comprobar("sum_valido", 32'(res_valido), 32'd1);
      comprobar("sum_dato", 32'(res_dato), 32'h0100);
      comprobar("sum_flags", 32'({res_acarreo, res_cero, res_error}), 32'b100);
      tomar();

      // PRO, and AND with zero result
      enviar(3'd2, 8'd200, 8'd3);
      ciclos(1);
      comprobar("pro_dato", 32'(res_dato), 32'd600);
      comprobar("pro_acarreo", 32'(res_acarreo), 32'd0);
      tomar();
      enviar(3'd5, 8'hF0, 8'h0F);
      ciclos(1);
      comprobar("and_dato", 32'(res_dato), 32'd0);
      comprobar("and_cero", 32'(res_cero), 32'd1);
      tomar();

      // Division / modulo by zero
      enviar(3'd3, 8'd9, 8'd0);
      ciclos(1);
      comprobar("div0_error", 32'(res_error), 32'd1);
      comprobar("div0_dato", 32'(res_dato), 32'd0);
      comprobar("div0_cuenta", 32'(err_cuenta), 32'd1);
      tomar();
      enviar(3'd4, 8'd9, 8'd0);
      ciclos(1);
      comprobar("mod0_cuenta", 32'(err_cuenta), 32'd2);
      tomar();
      enviar(3'd3, 8'd9, 8'd2);
      ciclos(1);
      comprobar("div_dato", 32'(res_dato), 32'd4);
      comprobar("div_error", 32'(res_error), 32'd0);
      tomar();

      // Saturation of the error counter
      res_listo = 1'b1;
      for (int i = 0; i < 260; i++) enviar(3'd3, 8'($urandom), 8'd0);
      ciclos(2);
      comprobar("err_saturado", 32'(err_cuenta), 32'd255);
      drenar();

      // Backpressure: four fill the FIFO, the fifth waits
      res_listo = 1'b0;
      for (int i = 0; i < 4; i++) enviar(3'd0, 8'(i * 16 + 3), 8'(250 - i));
      ciclos(1);
      cmd_op = 3'd0; cmd_a = 8'h77; cmd_b = 8'h99; cmd_valido = 1'b1;
      @(negedge clk);
      comprobar("lleno_listo_a", 32'(cmd_listo), 32'd0);
      @(negedge clk);
      comprobar("lleno_listo_b", 32'(cmd_listo), 32'd0);
      @(posedge clk); #1;
      tomar();
      found = 1'b0;
      for (int i = 0; i < 3 && !found; i++) begin
         @(negedge clk);
         found = cmd_listo;
      end
      comprobar("quinto_aceptado", 32'(found), 32'd1);
      @(posedge clk); #1;
      cmd_valido = 1'b0;
      drenar();

      // Streaming with the consumer always ready: pointers wrap
      res_listo = 1'b1;
      for (int i = 0; i < 12; i++) enviar(3'd7, 8'($urandom), 8'($urandom));
      drenar();

      // Randomized mix with random backpressure
      aleat = 1'b1;
      for (int i = 0; i < 80; i++) begin
         logic [7:0] b;
         b = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
         enviar(3'($urandom), 8'($urandom), b);
         if (($urandom % 3) == 0) ciclos(int'($urandom_range(1, 3)));
      end
      aleat = 1'b0;
      drenar();

      // Reset while executing with two entries queued
      res_listo = 1'b0;
      enviar(3'd0, 8'd10, 8'd20);
      enviar(3'd1, 8'd5, 8'd7);
      enviar(3'd6, 8'h12, 8'h34);
      #2;
      rst_n = 1'b0;
      #1;
      comprobar("rst_async_valido", 32'(res_valido), 32'd0);
      comprobar("rst_async_listo", 32'(cmd_listo), 32'd0);
      comprobar("rst_async_alu", 32'({alu_op, alu_dato0, alu_dato1}), 32'd0);
      ciclos(2);
      rst_n = 1'b1;
      ciclos(3);
      comprobar("sin_residuo", 32'(res_valido), 32'd0);
      enviar(3'd0, 8'd1, 8'd2);
      ciclos(1);
      comprobar("post_rst_dato", 32'(res_dato), 32'd3);
      drenar();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
